aes_bist_ctrl: RTL and testbench

//  Sequencer for the AES BIST wrapper. On a start pulse it selects BIST mode,

---
 rtl/aes_bist_ctrl.sv | 143 ++++++++++++++
 tb/tb_aes_bist_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/aes_bist_ctrl.sv
// AES BIST sequencer: arms the BIST wrapper, runs the LFSRs/MISR for a
// fixed number of cycles and counts DONE pulses. It then captures the MISR
// signature and grades it against the golden value.
module aes_bist_ctrl #(
  parameter int         RUN_CYCLES = 1024,
  parameter int         MIN_BLOCKS = 1,
  parameter logic [7:0] GOLDEN_SIG = 8'hC0,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       bist_d_out,
  input  logic             bist_done,
  output logic             is_bist,
  output logic             en_lsfr_misr,
  output logic             busy,
  output logic             finish,
  output logic             pass,
  output logic             fail,
  output logic             blk_short,
  output logic [7:0]       sig_out,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_BLK  = CNT_W'(MIN_BLOCKS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    RESULT  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cyc_cnt;

  // Block counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + 1'b1;
  endfunction

  // Grade a finished run: signature must match and enough blocks must have completed.
  function automatic logic run_ok(input logic [7:0] sig, input logic [CNT_W-1:0] blks);
    return (sig == GOLDEN_SIG) && (blks >= MIN_BLK);
  endfunction

  // Sequencer FSM; every output is a register updated on state transitions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cyc_cnt      <= '0;
      is_bist      <= 1'b0;
      en_lsfr_misr <= 1'b0;
      busy         <= 1'b0;
      finish       <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      blk_short    <= 1'b0;
      sig_out      <= '0;
      blk_cnt      <= '0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          // abort outranks a simultaneous start
          if (start && !abort) begin
            state     <= ARM;
            is_bist   <= 1'b1;
            busy      <= 1'b1;
            pass      <= 1'b0;
            fail      <= 1'b0;
            blk_short <= 1'b0;
            blk_cnt   <= '0;
            cyc_cnt   <= '0;
          end
        end
        ARM: begin
          // one cycle with the mux switched before the LFSRs start moving
          if (abort) begin
            state        <= IDLE;
            is_bist      <= 1'b0;
            en_lsfr_misr <= 1'b0;
            busy         <= 1'b0;
          end else begin
            state        <= RUN;
            en_lsfr_misr <= 1'b1;
            cyc_cnt      <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state        <= IDLE;
            is_bist      <= 1'b0;
            en_lsfr_misr <= 1'b0;
            busy         <= 1'b0;
          end else begin
            if (bist_done) blk_cnt <= sat_inc(blk_cnt);
            if (cyc_cnt == RUN_LAST) begin
              state        <= CAPTURE;
              en_lsfr_misr <= 1'b0;
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
        end
        CAPTURE: begin
          // MISR is frozen (enable low) so d_out is a stable signature here
          if (abort) begin
            state        <= IDLE;
            is_bist      <= 1'b0;
            en_lsfr_misr <= 1'b0;
            busy         <= 1'b0;
          end else begin
            sig_out <= bist_d_out;
            state   <= RESULT;
          end
        end
        RESULT: begin
          // abort is deliberately ignored: the run has already completed
          finish    <= 1'b1;
          pass      <= run_ok(sig_out, blk_cnt);
          fail      <= !run_ok(sig_out, blk_cnt);
          blk_short <= (blk_cnt < MIN_BLK);
          state     <= IDLE;
          is_bist   <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          is_bist      <= 1'b0;
          en_lsfr_misr <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_bist_ctrl.sv
// Directed bench for the AES BIST sequencer.
module tb_aes_bist_ctrl;

  localparam int RC    = 1024;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [7:0]       bist_d_out = 8'h00;
  logic             bist_done = 1'b0;
  logic             is_bist, en_lsfr_misr, busy, finish, pass, fail, blk_short;
  logic [7:0]       sig_out;
  logic [CNT_W-1:0] blk_cnt;

  int checks   = 0;
  int failures = 0;

  aes_bist_ctrl #(
    .RUN_CYCLES(RC),
    .MIN_BLOCKS(1),
    .GOLDEN_SIG(8'hC0),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .bist_d_out(bist_d_out),
    .bist_done(bist_done),
    .is_bist(is_bist),
    .en_lsfr_misr(en_lsfr_misr),
    .busy(busy),
    .finish(finish),
    .pass(pass),
    .fail(fail),
    .blk_short(blk_short),
    .sig_out(sig_out),
    .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE. Raises start for one edge (edge S), then
  // walks k = 0.. (negedge after posedge S+k). bist_done is driven at k=0
  // (ARM), k=1..n_done (RUN) and k=RC+1 (CAPTURE); only the RUN ones count.
  task automatic run(input int n_done, input int abort_k, input int restart_k,
                     output int en_cnt, output int fin_k, output int fin_cnt,
                     output logic [2:0] arm_snap, output logic [2:0] post_abort);
    en_cnt     = 0;
    fin_k      = -1;
    fin_cnt    = 0;
    arm_snap   = 3'bxxx;
    post_abort = 3'bxxx;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= RC + 6; k++) begin
      if (k == 0) arm_snap = {is_bist, en_lsfr_misr, busy};
      if (k == abort_k + 1) post_abort = {en_lsfr_misr, is_bist, busy};
      if (en_lsfr_misr) en_cnt++;
      if (finish) begin
        fin_cnt++;
        if (fin_k < 0) fin_k = k;
      end
      bist_done = (k == 0) || (k >= 1 && k <= n_done) || (k == RC + 1);
      abort     = (k == abort_k);
      start     = (k == restart_k);
      @(posedge clk);
      @(negedge clk);
    end
    bist_done = 1'b0;
    abort     = 1'b0;
    start     = 1'b0;
  endtask

  int         en_cnt, fin_k, fin_cnt;
  logic [2:0] arm_snap, post_abort;

  initial begin
    // reset state
    #2 rst = 1'b0;
    #1;
    check("rst_is_bist", is_bist, 0);
    check("rst_en", en_lsfr_misr, 0);
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    check("rst_pass_fail_short", {pass, fail, blk_short}, 0);
    check("rst_sig_out", sig_out, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // start and abort together in IDLE: stays IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", {busy, is_bist}, 0);
    @(negedge clk);

    // test 1: good signature, 3 blocks
    bist_d_out = 8'hC0;
    run(3, -1, -1, en_cnt, fin_k, fin_cnt, arm_snap, post_abort);
    check("t1_arm_state", arm_snap, 3'b101);
    check("t1_en_cycles", en_cnt, RC);
    check("t1_finish_latency", fin_k + 1, RC + 4);
    check("t1_finish_count", fin_cnt, 1);
    check("t1_pass_fail_short", {pass, fail, blk_short}, 3'b100);
    check("t1_sig_out", sig_out, 8'hC0);
    check("t1_blk_cnt", blk_cnt, 3);
    check("t1_idle_after", {busy, is_bist, en_lsfr_misr}, 0);

    // test 2: wrong signature
    bist_d_out = 8'h3F;
    run(2, -1, -1, en_cnt, fin_k, fin_cnt, arm_snap, post_abort);
    check("t2_pass_fail_short", {pass, fail, blk_short}, 3'b010);
    check("t2_sig_out", sig_out, 8'h3F);
    check("t2_blk_cnt", blk_cnt, 2);

    // test 3: no DONE pulses during RUN
    bist_d_out = 8'hC0;
    run(0, -1, -1, en_cnt, fin_k, fin_cnt, arm_snap, post_abort);
    check("t3_pass_fail_short", {pass, fail, blk_short}, 3'b011);
    check("t3_blk_cnt", blk_cnt, 0);
    check("t3_sig_out", sig_out, 8'hC0);

    // test 4: abort at RUN cycle 5
    bist_d_out = 8'h55;
    run(2, 5, -1, en_cnt, fin_k, fin_cnt, arm_snap, post_abort);
    check("t4_post_abort", post_abort, 3'b000);
    check("t4_no_finish", fin_cnt, 0);
    check("t4_en_cycles", en_cnt, 5);
    check("t4_pass_fail", {pass, fail}, 2'b00);
    check("t4_sig_kept", sig_out, 8'hC0);
    check("t4_blk_cnt", blk_cnt, 2);

    // abort arriving in RESULT is ignored
    bist_d_out = 8'hC0;
    run(1, RC + 2, -1, en_cnt, fin_k, fin_cnt, arm_snap, post_abort);
    check("abort_result_finish", fin_cnt, 1);
    check("abort_result_pass", {pass, fail}, 2'b10);

    // test 5: start pulsed again mid-RUN
    run(1, -1, 10, en_cnt, fin_k, fin_cnt, arm_snap, post_abort);
    check("t5_finish_latency", fin_k + 1, RC + 4);
    check("t5_finish_count", fin_cnt, 1);
    check("t5_en_cycles", en_cnt, RC);
    check("t5_pass", {pass, fail}, 2'b10);
    check("t5_blk_cnt", blk_cnt, 1);

    // test 6: asynchronous reset mid-RUN
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_running", {is_bist, en_lsfr_misr, busy}, 3'b111);
    #2 rst = 1'b0;
    #1;
    check("t6_async_ctrl", {is_bist, en_lsfr_misr, busy, finish}, 0);
    check("t6_async_flags", {pass, fail, blk_short}, 0);
    check("t6_async_sig", sig_out, 0);
    check("t6_async_blk", blk_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_idle_after", {is_bist, en_lsfr_misr, busy}, 0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("t6_restart_arm", {is_bist, en_lsfr_misr, busy}, 3'b101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
